// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: command-side driver for a combinational alu32. Registers one
// command's operands onto the ALU inputs and captures the result one cycle
// later into an in-order FWFT response FIFO. It also keeps a result
// accumulator that can be fed back as operand A.

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module alu_cmd_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  alu_op_t                cmd_op,
  input  logic [31:0]            cmd_a,
  input  logic [31:0]            cmd_b,
  input  logic                   cmd_use_acc,
  input  logic                   acc_clr,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output alu_op_t                alu_op,
  input  logic [31:0]            alu_y,
  input  logic [3:0]             alu_flags,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_y,
  output logic [3:0]             rsp_flags,
  output logic [$clog2(DEPTH):0] rsp_count,
  output logic [31:0]            acc_q
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

  state_t           state;
  state_t           state_next;
  logic             push;
  logic             pop;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [31:0]      mem_y     [DEPTH];
  logic [3:0]       mem_flags [DEPTH];

  assign rsp_valid = (rsp_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_y     = rsp_valid ? mem_y[rd_ptr]     : '0;
  assign rsp_flags = rsp_valid ? mem_flags[rd_ptr] : '0;

  // Next state and handshake. New commands are admitted only while the
  // FIFO has room, so the EXEC push can never overflow.
  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    push       = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = (rsp_count < CNT_W'(DEPTH));
        if (cmd_valid && cmd_ready) state_next = EXEC;
      end
      EXEC: begin
        push       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rsp_count <= '0;
    end else begin
      state <= state_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   rsp_count <= rsp_count + CNT_W'(1);
        2'b01:   rsp_count <= rsp_count - CNT_W'(1);
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  // Operand registers toward alu32. They load on accept and hold otherwise.
  // Operand A taps the accumulator value from before any coincident clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= ALU_ADD;
    end else if (cmd_valid && cmd_ready) begin
      alu_a  <= cmd_use_acc ? acc_q : cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
    end
  end

  // Accumulator takes each writeback. A clear in the same cycle wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr) begin
      acc_q <= '0;
    end else if (push) begin
      acc_q <= alu_y;
    end
  end

  // Response storage. Contents are only observed through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y[wr_ptr]     <= alu_y;
      mem_flags[wr_ptr] <= alu_flags;
    end
  end

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Testbench for alu_cmd_seq. A behavioural alu32 sits on the ALU ports.
// Table vectors and hand-written sequences push expected responses into a
// scoreboard queue. The queue is popped as the DUT's FIFO head is consumed.
`timescale 1ns/1ps
module tb_alu_cmd_seq;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   cmd_valid;
  logic                   cmd_ready;
  alu_op_t                cmd_op;
  logic [31:0]            cmd_a;
  logic [31:0]            cmd_b;
  logic                   cmd_use_acc;
  logic                   acc_clr;
  logic [31:0]            alu_a;
  logic [31:0]            alu_b;
  alu_op_t                alu_op;
  logic [31:0]            alu_y;
  logic [3:0]             alu_flags;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [31:0]            rsp_y;
  logic [3:0]             rsp_flags;
  logic [$clog2(DEPTH):0] rsp_count;
  logic [31:0]            acc_q;

  alu_cmd_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .acc_clr(acc_clr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y),
    .rsp_flags(rsp_flags), .rsp_count(rsp_count), .acc_q(acc_q)
  );

  always #5 clk = ~clk;

  // Behavioural alu32: {y, z, n, c, v}; c is carry for ADD, not-borrow for SUB.
  function automatic logic [35:0] alu_model(input alu_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] y;
    logic        c;
    logic        v;
    y = '0; c = 1'b0; v = 1'b0;
    case (op)
      ALU_ADD:  begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32];
                      v = (a[31] == b[31]) && (y[31] != a[31]); end
      ALU_SUB:  begin y = a - b; c = (a >= b);
                      v = (a[31] != b[31]) && (y[31] != a[31]); end
      ALU_AND:  y = a & b;
      ALU_OR:   y = a | b;
      ALU_XOR:  y = a ^ b;
      ALU_SLL:  y = a << b[4:0];
      ALU_SRL:  y = a >> b[4:0];
      ALU_SRA:  y = $signed(a) >>> b[4:0];
      ALU_SLT:  y = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {31'd0, (a < b)};
      default:  y = '0;
    endcase
    return {y, (y == 32'd0), y[31], c, v};
  endfunction

  always_comb {alu_y, alu_flags} = alu_model(alu_op, alu_a, alu_b);

  typedef struct {
    logic [31:0] y;
    logic [3:0]  fl;
  } exp_t;

  typedef struct {
    alu_op_t     op;
    logic [31:0] a;
    logic [31:0] b;
    logic        use_acc;
    logic [31:0] exp_a;
    logic [31:0] y;
    logic [3:0]  fl;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic accepted;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes on the falling edge, then step past the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    accepted = cmd_valid && cmd_ready;
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: got response y=%h, want no response", rsp_y);
      end else begin
        e = sb.pop_front();
        check("sb_y", rsp_y, e.y);
        check("sb_flags", 32'(rsp_flags), 32'(e.fl));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic ua, input logic exp_rsp, input logic [31:0] ey,
                       input logic [3:0] ef);
    int   n;
    exp_t e;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = ua;
    n = 0;
    do begin tick(); n++; end while (!accepted && n < 40);
    cmd_valid = 1'b0;
    cmd_use_acc = 1'b0;
    if (!accepted) begin
      n_cmp++;
      n_bad++;
      $display("FAIL issue_timeout: got no accept, want accept within 40 cycles");
    end else if (exp_rsp) begin
      e.y = ey; e.fl = ef;
      sb.push_back(e);
    end
  endtask

  // Single command with an empty FIFO: check operands, latency and accumulator.
  task automatic run_vec(input vec_t v);
    issue(v.op, v.a, v.b, v.use_acc, 1'b1, v.y, v.fl);
    check("exec_alu_a", alu_a, v.exp_a);
    check("exec_alu_b", alu_b, v.b);
    check("exec_alu_op", 32'(alu_op), 32'(v.op));
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("wb_rsp_valid", 32'(rsp_valid), 32'd1);
    check("wb_rsp_count", 32'(rsp_count), 32'd1);
    check("wb_acc_q", acc_q, v.y);
    tick();
    check("pop_rsp_count", 32'(rsp_count), 32'd0);
  endtask

  initial begin
    int   n;
    logic any_acc;

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = ALU_ADD; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; acc_clr = 1'b0; rsp_ready = 1'b1;

    vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1010};
    vecs[1]  = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 4'b0011};
    vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000};
    vecs[3]  = '{ALU_ADD,  32'h0000_0005, 32'h0000_0000, 1'b0, 32'h0000_0005, 32'h0000_0005, 4'b0000};
    vecs[4]  = '{ALU_ADD,  32'hDEAD_BEEF, 32'h0000_0003, 1'b1, 32'h0000_0005, 32'h0000_0008, 4'b0000};
    vecs[5]  = '{ALU_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 32'hF0F0_F0F0, 32'h00F0_00F0, 4'b0000};
    vecs[6]  = '{ALU_XOR,  32'h1234_5678, 32'h1234_5678, 1'b0, 32'h1234_5678, 32'h0000_0000, 4'b1000};
    vecs[7]  = '{ALU_SLL,  32'h0000_0001, 32'h0000_0004, 1'b0, 32'h0000_0001, 32'h0000_0010, 4'b0000};
    vecs[8]  = '{ALU_SRA,  32'h8000_0000, 32'h0000_0004, 1'b0, 32'h8000_0000, 32'hF800_0000, 4'b0100};
    vecs[9]  = '{ALU_SUB,  32'h0000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0100};
    vecs[10] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 4'b0101};
    vecs[11] = '{ALU_SRL,  32'h8000_0000, 32'h0000_001F, 1'b0, 32'h8000_0000, 32'h0000_0001, 4'b0000};
    vecs[12] = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1000};

    // Reset
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_count", 32'(rsp_count), 32'd0);
    check("rst_rsp_y", rsp_y, 32'd0);
    check("rst_acc_q", acc_q, 32'd0);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_alu_a", alu_a, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table vectors
    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Chain with a clear coincident with writeback: result still pushed
    run_vec('{ALU_ADD, 32'd5, 32'd0, 1'b0, 32'd5, 32'd5, 4'b0000});
    issue(ALU_ADD, 32'h1111_1111, 32'd3, 1'b1, 1'b1, 32'd8, 4'b0000);
    check("chain_alu_a", alu_a, 32'd5);
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    check("clr_wb_acc_q", acc_q, 32'd0);
    check("clr_wb_rsp_valid", 32'(rsp_valid), 32'd1);
    tick();

    // Clear coincident with accept: operand A takes the pre-clear value
    run_vec('{ALU_ADD, 32'd9, 32'd0, 1'b0, 32'd9, 32'd9, 4'b0000});
    acc_clr = 1'b1;
    issue(ALU_ADD, 32'h2222_2222, 32'd1, 1'b1, 1'b1, 32'd10, 4'b0000);
    acc_clr = 1'b0;
    check("clr_acc_alu_a", alu_a, 32'd9);
    check("clr_acc_acc_q", acc_q, 32'd0);
    tick();
    check("clr_acc_wb_acc_q", acc_q, 32'd10);
    tick();

    // Backpressure: fill the FIFO, the fifth command waits for the first pop
    rsp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      issue(ALU_ADD, 32'(i * 16), 32'd1, 1'b0, 1'b1, 32'(i * 16 + 1), 4'b0000);
    end
    tick();
    cmd_valid = 1'b1; cmd_op = ALU_ADD; cmd_a = 32'h50; cmd_b = 32'd1; cmd_use_acc = 1'b0;
    any_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      any_acc = any_acc | accepted;
    end
    check("bp_no_accept", 32'(any_acc), 32'd0);
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_rsp_count", 32'(rsp_count), 32'd4);
    check("bp_head_y", rsp_y, 32'h11);
    rsp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!accepted && n < 20);
    cmd_valid = 1'b0;
    check("bp_accept_wait", 32'(n), 32'd2);
    check("bp_count_at_accept", 32'(rsp_count), 32'd2);
    if (accepted) sb.push_back('{32'h51, 4'b0000});
    n = 0;
    while (sb.size() != 0 && n < 30) begin tick(); n++; end
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_final_count", 32'(rsp_count), 32'd0);

    // Reset while a command is in EXEC: its result is dropped
    issue(ALU_SLL, 32'd1, 32'd4, 1'b0, 1'b0, 32'd16, 4'b0000);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rmid_rsp_count", 32'(rsp_count), 32'd0);
    check("rmid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rmid_rsp_y", rsp_y, 32'd0);
    check("rmid_acc_q", acc_q, 32'd0);
    tick();
    tick();
    check("rmid_no_late_push", 32'(rsp_valid), 32'd0);
    check("rmid_cmd_ready", 32'(cmd_ready), 32'd1);

    check("sb_empty_at_end", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
